bp_me_mem_cmd_arbiter: RTL and testbench
========================================

# bp_me_mem_cmd_arbiter

Shares one memory command/response port pair between `num_req_p` requesters, such as CCE instances and an I/O master, in the memory-end (ME) subsystem. Commands are granted round-robin. The requester ID of every accepted command is recorded in order, so each memory response is routed back to the requester that issued the matching command. The memory side is in-order; the arbiter caps outstanding commands at `max_outstanding_p`.

## Interface
- `num_req_p`, 4: number of requesters, at least 2.
- `cmd_width_p`, 128: packed memory command width (header plus payload).
- `resp_width_p`, 128: packed memory response width.
- `max_outstanding_p`, 8: ID FIFO depth, a power of 2.
- `clk_i` in 1: the only clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `req_cmd_i` in `num_req_p*cmd_width_p`: requester commands, slice r belongs to requester r.
- `req_v_i` in `num_req_p`: per-requester command valid.
- `req_ready_o` out `num_req_p`: per-requester command accept; one-hot or zero.
- `mem_cmd_o` out `cmd_width_p`: selected command.
- `mem_cmd_v_o` out 1: command valid toward memory.
- `mem_cmd_ready_i` in 1: memory accepts the command.
- `mem_resp_i` in `resp_width_p`: memory response.
- `mem_resp_v_i` in 1: response valid.
- `mem_resp_ready_o` out 1: response accepted.
- `resp_o` out `resp_width_p`: `mem_resp_i` broadcast to all requesters.
- `resp_v_o` out `num_req_p`: one-hot valid for the owning requester.
- `resp_ready_i` in `num_req_p`: requester response ready.
- `outstanding_o` out `clog2(max_outstanding_p+1)`: current count of in-flight commands.
- `err_o` out 1: sticky flag, set by a response that arrives while nothing is outstanding.

## Operation
- Round-robin pointer `last_r` holds the index of the last granted requester.
  - Priority order is `last_r+1` … `last_r`, wrapping modulo `num_req_p`.
  - On reset `last_r = num_req_p-1`, so requester 0 has top priority.
- Two states:
  - **IDLE**:
    - If the ID FIFO is not full and any `req_v_i` is high, grant the highest-priority valid requester g.
    - Drive `mem_cmd_o` from slice g and raise `mem_cmd_v_o`.
    - If `mem_cmd_ready_i` is high, the handshake completes: assert `req_ready_o[g]`, push g into the FIFO, set `last_r = g`, stay in IDLE.
    - Otherwise go to LOCKED with `lock_id_r = g`.
  - **LOCKED**:
    - The grant is held on `lock_id_r` regardless of other requesters' valids.
    - `mem_cmd_v_o = req_v_i[lock_id_r]`. A requester must not drop valid before the handshake completes; this is checked by an assertion.
    - On handshake: push the ID, update `last_r`, return to IDLE.
- FIFO full: `mem_cmd_v_o = 0` and all `req_ready_o = 0`.
  - A push is blocked while the FIFO is full, even if a pop happens in the same cycle.
  - The FIFO is never full while in LOCKED: entry to LOCKED requires not-full, and pops only lower occupancy.
- Response routing:
  - h is the FIFO head.
  - `resp_v_o[h] = mem_resp_v_i & ~empty`.
  - `mem_resp_ready_o = resp_ready_i[h] & ~empty`.
  - On handshake, pop the FIFO.
- FIFO empty: `mem_resp_ready_o = 0` and all `resp_v_o = 0`. If `mem_resp_v_i` is high in this state, set `err_o` (sticky until reset).
- Simultaneous push and pop in one cycle: `outstanding_o` is unchanged.
- The arbiter never inspects message contents. Payload-carrying messages follow the codebase-wide payload masks, are single-beat, and pass through unmodified.

## Timing
- Reset values while `reset_n_i` is low:
  - `last_r = num_req_p-1`.
  - State IDLE, FIFO empty, `outstanding_o = 0`, `err_o = 0`.
  - All `_v_o` and `req_ready_o` outputs are 0.
- Reset asserted mid-transaction discards the LOCKED grant and all FIFO contents; responses still in flight afterwards set `err_o`.
- Command path is combinational from `req_v_i` to `mem_cmd_v_o`/`mem_cmd_o`: zero added latency, no registered buffer.
- Response path is combinational from `mem_resp_v_i`/`resp_ready_i` to `resp_v_o`/`mem_resp_ready_o`: zero added latency.
- State, `last_r`, `lock_id_r`, FIFO and `outstanding_o` update on the rising edge of `clk_i` at the handshake cycle.
- Sustained throughput with memory always ready: one command per cycle and one response per cycle, up to `max_outstanding_p` in flight.

## Structure
- The ID width constant and the state enum (`e_arb_idle`, `e_arb_locked`) belong in `bp_me_pkg`.
- One sub-module: `bp_me_req_id_fifo`.
  - Depth `max_outstanding_p`, width `clog2(num_req_p)`.
  - Asynchronous active-low reset.
  - Ports: `full_o`, `empty_o`, `count_o`.
- The round-robin select is inline logic.

## Test plan
- All four requesters hold valid and memory is always ready → grants in order 0,1,2,3,0 on consecutive cycles.
- Requester 2 valid, memory not ready for 3 cycles, requester 0 raises valid at cycle 1 → grant stays on 2 for the full stall; requester 0 is granted on the cycle after 2's handshake.
- 8 commands accepted with no responses → `outstanding_o = 8`, the 9th request is stalled, `req_ready_o = 0`.
- FIFO full, and a response plus a new command arrive in the same cycle → response pops, command is blocked; the command is accepted the next cycle and `outstanding_o` returns to 8.
- Commands from requesters 3,1,1, then 3 responses → `resp_v_o` = 4'b1000, 4'b0010, 4'b0010.
  - Holding `resp_ready_i[3]` low stalls `mem_resp_ready_o`.
- `mem_resp_v_i` high after reset with no commands issued → `err_o` rises the next cycle and stays high. Then assert `reset_n_i` low mid-LOCKED → all outputs return to 0 immediately, asynchronously.

Source files
------------

// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types and helpers for the memory-end command arbiter.
package bp_me_pkg;
  typedef enum logic {e_arb_idle, e_arb_locked} arb_state_e;
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_me_mem_cmd_arbiter_if.sv
// bp_me_mem_cmd_arbiter_if: requester, memory and response bundle around the arbiter.
interface bp_me_mem_cmd_arbiter_if #(
  parameter int num_req_p = 4,
  parameter int cmd_width_p = 128,
  parameter int resp_width_p = 128,
  parameter int max_outstanding_p = 8
);
  localparam int out_width_lp = $clog2(max_outstanding_p + 1);
  logic [num_req_p*cmd_width_p-1:0] req_cmd_i;
  logic [num_req_p-1:0] req_v_i;
  logic [num_req_p-1:0] req_ready_o;
  logic [cmd_width_p-1:0] mem_cmd_o;
  logic mem_cmd_v_o;
  logic mem_cmd_ready_i;
  logic [resp_width_p-1:0] mem_resp_i;
  logic mem_resp_v_i;
  logic mem_resp_ready_o;
  logic [resp_width_p-1:0] resp_o;
  logic [num_req_p-1:0] resp_v_o;
  logic [num_req_p-1:0] resp_ready_i;
  logic [out_width_lp-1:0] outstanding_o;
  logic err_o;
  modport master (
    input req_cmd_i, req_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_ready_i,
    output req_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o, resp_o, resp_v_o,
    outstanding_o, err_o
  );
  modport slave (
    output req_cmd_i, req_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_ready_i,
    input req_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o, resp_o, resp_v_o,
    outstanding_o, err_o
  );
endinterface

// File: rtl/bp_me_req_id_fifo.sv
// bp_me_req_id_fifo: in-order requester-ID queue tracking outstanding memory commands.
module bp_me_req_id_fifo #(
  parameter int depth_p = 8,
  parameter int width_p = 2,
  localparam int ptr_w = $clog2(depth_p),
  localparam int cnt_w = $clog2(depth_p + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic push_i,
  input  logic [width_p-1:0] data_i,
  input  logic pop_i,
  output logic [width_p-1:0] data_o,
  output logic full_o,
  output logic empty_o,
  output logic [cnt_w-1:0] count_o
);
  logic [width_p-1:0] mem_r [depth_p];
  logic [ptr_w-1:0] wr_r, rd_r;
  logic [cnt_w-1:0] count_r;
  logic do_push, do_pop;
  assign full_o = count_r == cnt_w'(depth_p);
  assign empty_o = count_r == '0;
  assign count_o = count_r;
  assign data_o = mem_r[rd_r];
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  always_ff @(posedge clk_i)
    if (do_push) mem_r[wr_r] <= data_i;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wr_r <= '0;
      rd_r <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_r <= wr_r + 1'b1;
      if (do_pop) rd_r <= rd_r + 1'b1;
      count_r <= count_r + cnt_w'(do_push) - cnt_w'(do_pop);
    end
endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// bp_me_mem_cmd_arbiter: round-robin memory command arbiter with in-order response routing.
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p = 4,
  parameter int cmd_width_p = 128,
  parameter int resp_width_p = 128,
  parameter int max_outstanding_p = 8
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_me_mem_cmd_arbiter_if.master io
);
  localparam int id_w = id_width(num_req_p);
  localparam int out_w = $clog2(max_outstanding_p + 1);
  typedef logic [id_w-1:0] id_t;
  arb_state_e state_r, state_n;
  id_t last_r, lock_id_r, rr_grant, sel, head;
  logic rr_any, full, empty, cmd_v, cmd_hs, resp_hs, err_r;
  logic [out_w-1:0] count;
  always_comb begin
    rr_any = 1'b0;
    rr_grant = last_r;
    for (int i = 1; i <= num_req_p; i++)
      if (!rr_any && io.req_v_i[id_w'((int'(last_r) + i) % num_req_p)]) begin
        rr_any = 1'b1;
        rr_grant = id_w'((int'(last_r) + i) % num_req_p);
      end
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_r <= e_arb_idle;
    else state_r <= state_n;
  always_comb begin
    state_n = state_r == e_arb_idle ? (cmd_v && !io.mem_cmd_ready_i ? e_arb_locked : e_arb_idle)
                                    : (cmd_hs ? e_arb_idle : e_arb_locked);
  end
  // Outputs are forced low during reset so no requester sees a grant before the arbiter is live.
  always_comb begin
    sel = state_r == e_arb_locked ? lock_id_r : rr_grant;
    cmd_v = reset_n_i & ~full & (state_r == e_arb_locked ? io.req_v_i[lock_id_r] : rr_any);
    cmd_hs = cmd_v & io.mem_cmd_ready_i;
    io.mem_cmd_v_o = cmd_v;
    io.mem_cmd_o = io.req_cmd_i[sel*cmd_width_p +: cmd_width_p];
    io.req_ready_o = cmd_hs ? num_req_p'(1) << sel : '0;
    io.mem_resp_ready_o = ~empty & io.resp_ready_i[head];
    io.resp_v_o = io.mem_resp_v_i && !empty ? num_req_p'(1) << head : '0;
    resp_hs = io.mem_resp_v_i & io.mem_resp_ready_o;
    io.resp_o = io.mem_resp_i;
    io.outstanding_o = count;
    io.err_o = err_r;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      last_r <= id_w'(num_req_p - 1);
      lock_id_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (cmd_hs) last_r <= sel;
      if (state_r == e_arb_idle && cmd_v && !io.mem_cmd_ready_i) lock_id_r <= rr_grant;
      if (io.mem_resp_v_i && empty) err_r <= 1'b1;
    end
  bp_me_req_id_fifo #(.depth_p(max_outstanding_p), .width_p(id_w)) id_fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .push_i(cmd_hs),
    .data_i(sel),
    .pop_i(resp_hs),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    state_r == e_arb_locked |-> io.req_v_i[lock_id_r]);
endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb_bp_me_mem_cmd_arbiter: vector table plus directed reset/error sequences for the arbiter.
module tb_bp_me_mem_cmd_arbiter;
  localparam int n = 4, cw = 16, rw = 16, mo = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  bp_me_mem_cmd_arbiter_if #(.num_req_p(n), .cmd_width_p(cw), .resp_width_p(rw), .max_outstanding_p(mo)) bus ();
  bp_me_mem_cmd_arbiter #(.num_req_p(n), .cmd_width_p(cw), .resp_width_p(rw), .max_outstanding_p(mo)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .io(bus.master)
  );
  typedef struct packed {
    logic [3:0] rv;
    logic crdy;
    logic rsp_v;
    logic [3:0] rrdy;
    logic [3:0] e_rr;
    logic e_cv;
    logic [1:0] e_g;
    logic [3:0] e_rsv;
    logic e_mrr;
    logic [3:0] e_out;
  } vec_t;
  vec_t vq[$];
  int errors = 0, checks = 0;
  function automatic void add(int rv, int crdy, int rsp_v, int rrdy, int e_rr, int e_cv, int e_g,
                              int e_rsv, int e_mrr, int e_out);
    vec_t v;
    v.rv = 4'(rv); v.crdy = 1'(crdy); v.rsp_v = 1'(rsp_v); v.rrdy = 4'(rrdy);
    v.e_rr = 4'(e_rr); v.e_cv = 1'(e_cv); v.e_g = 2'(e_g); v.e_rsv = 4'(e_rsv);
    v.e_mrr = 1'(e_mrr); v.e_out = 4'(e_out);
    vq.push_back(v);
  endfunction
  function automatic logic [15:0] cmd_of(int g);
    return 16'(16'hC0C0 + 16'h0101 * g);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input int rv, input int crdy, input int rsp_v, input int rrdy);
    bus.req_v_i = 4'(rv);
    bus.mem_cmd_ready_i = 1'(crdy);
    bus.mem_resp_v_i = 1'(rsp_v);
    bus.resp_ready_i = 4'(rrdy);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t v;
    for (int k = 0; k < 5; k++) add('hF, 1, 0, 0, 1 << (k % 4), 1, k % 4, 0, 0, k);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 'hF, 0, 0, 0, 1 << (k % 4), 1, 5 - k);
    add('b0100, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add('b0101, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add('b0101, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    add('b0101, 1, 0, 0, 'b0100, 1, 2, 0, 0, 0);
    add('b0001, 1, 0, 0, 'b0001, 1, 0, 0, 0, 1);
    add(0, 0, 1, 'hF, 0, 0, 0, 'b0100, 1, 2);
    add(0, 0, 1, 'hF, 0, 0, 0, 'b0001, 1, 1);
    for (int k = 0; k < 8; k++) add('hF, 1, 0, 0, 1 << ((k + 1) % 4), 1, (k + 1) % 4, 0, 0, k);
    add('hF, 1, 0, 0, 0, 0, 0, 0, 0, 8);
    add('hF, 1, 1, 'hF, 0, 0, 0, 'b0010, 1, 8);
    add('hF, 1, 0, 0, 'b0010, 1, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    for (int k = 0; k < 8; k++) add(0, 0, 1, 'hF, 0, 0, 0, 1 << ((k + 2) % 4), 1, 8 - k);
    add('b1000, 1, 0, 0, 'b1000, 1, 3, 0, 0, 0);
    add('b0010, 1, 0, 0, 'b0010, 1, 1, 0, 0, 1);
    add('b0010, 1, 0, 0, 'b0010, 1, 1, 0, 0, 2);
    add(0, 0, 1, 'b0111, 0, 0, 0, 'b1000, 0, 3);
    add(0, 0, 1, 'hF, 0, 0, 0, 'b1000, 1, 3);
    add(0, 0, 1, 'hF, 0, 0, 0, 'b0010, 1, 2);
    add(0, 0, 1, 'hF, 0, 0, 0, 'b0010, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.req_cmd_i = {cmd_of(3), cmd_of(2), cmd_of(1), cmd_of(0)};
    bus.mem_resp_i = 16'h5A5A;
    drive('hF, 1, 1, 'hF);
    #2;
    chk("reset mem_cmd_v", 32'(bus.mem_cmd_v_o), 0);
    chk("reset req_ready", 32'(bus.req_ready_o), 0);
    chk("reset resp_v", 32'(bus.resp_v_o), 0);
    chk("reset mem_resp_ready", 32'(bus.mem_resp_ready_o), 0);
    chk("reset outstanding", 32'(bus.outstanding_o), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset err", 32'(bus.err_o), 0);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(32'(v.rv), 32'(v.crdy), 32'(v.rsp_v), 32'(v.rrdy));
      bus.mem_resp_i = 16'(16'h5A00 + i);
      #2;
      chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready_o), 32'(v.e_rr));
      chk($sformatf("v%0d mem_cmd_v", i), 32'(bus.mem_cmd_v_o), 32'(v.e_cv));
      if (v.e_cv) chk($sformatf("v%0d mem_cmd", i), 32'(bus.mem_cmd_o), 32'(cmd_of(32'(v.e_g))));
      chk($sformatf("v%0d resp_v", i), 32'(bus.resp_v_o), 32'(v.e_rsv));
      chk($sformatf("v%0d mem_resp_ready", i), 32'(bus.mem_resp_ready_o), 32'(v.e_mrr));
      if (v.rsp_v) chk($sformatf("v%0d resp", i), 32'(bus.resp_o), 32'(16'h5A00 + i));
      chk($sformatf("v%0d outstanding", i), 32'(bus.outstanding_o), 32'(v.e_out));
      chk($sformatf("v%0d err", i), 32'(bus.err_o), 0);
      tick();
    end
    drive(0, 0, 1, 0);
    #2;
    chk("stray resp_v", 32'(bus.resp_v_o), 0);
    chk("stray mem_resp_ready", 32'(bus.mem_resp_ready_o), 0);
    chk("err before edge", 32'(bus.err_o), 0);
    tick();
    chk("err set", 32'(bus.err_o), 1);
    drive(0, 0, 0, 0);
    tick();
    chk("err sticky", 32'(bus.err_o), 1);
    drive('b0001, 1, 0, 0);
    #2;
    chk("pre-lock grant", 32'(bus.req_ready_o), 'b0001);
    tick();
    chk("pre-lock outstanding", 32'(bus.outstanding_o), 1);
    drive('b0010, 0, 0, 0);
    tick();
    chk("locked mem_cmd_v", 32'(bus.mem_cmd_v_o), 1);
    chk("locked mem_cmd", 32'(bus.mem_cmd_o), 32'(cmd_of(1)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_cmd_v", 32'(bus.mem_cmd_v_o), 0);
    chk("async rst req_ready", 32'(bus.req_ready_o), 0);
    chk("async rst outstanding", 32'(bus.outstanding_o), 0);
    chk("async rst err", 32'(bus.err_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 'hF);
    #2;
    chk("post-rst resp_v", 32'(bus.resp_v_o), 0);
    chk("post-rst mem_resp_ready", 32'(bus.mem_resp_ready_o), 0);
    tick();
    chk("post-rst err", 32'(bus.err_o), 1);
    drive('b1010, 1, 0, 0);
    #2;
    chk("post-rst grant", 32'(bus.req_ready_o), 'b0010);
    chk("post-rst mem_cmd", 32'(bus.mem_cmd_o), 32'(cmd_of(1)));
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
